sha3_padding_unit: RTL

Front-end stage of the SHA3 core: accepts the message as a stream of 64-bit words and assembles R-bit rate blocks with SHA3 domain padding (0x06 … 0x80) applied. It presents each block, plus valid/last flags, to the permutation stage, which absorbs and permutes it. The unit holds one block at a time and applies back-pressure to the word source while a block waits for the permutation to take it.

---
 rtl/sha3_padding_unit_if.sv | 25 ++
 rtl/sha3_padding_unit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/sha3_padding_unit_if.sv
// Word-stream input and padded-block output bundle of the SHA3 padding front end.
// slave is the padding unit's view; master is the word source / permutation side.
interface sha3_padding_unit_if #(
  parameter int R_BLOCK_SIZE = 1152
);
  logic [63:0]             dataIn;
  logic                    dataValid;
  logic                    dataLast;
  logic [3:0]              dataBytes;
  logic                    dataReady;
  logic [0:R_BLOCK_SIZE-1] blockOut;
  logic                    blockValid;
  logic                    blockLast;
  logic                    permReady;

  modport slave (
    input  dataIn, dataValid, dataLast, dataBytes, permReady,
    output dataReady, blockOut, blockValid, blockLast
  );

  modport master (
    output dataIn, dataValid, dataLast, dataBytes, permReady,
    input  dataReady, blockOut, blockValid, blockLast
  );
endinterface

// File: rtl/sha3_padding_unit.sv
// Packs 64-bit message words into one R-bit rate block, applies SHA3 domain padding
// (0x06 ... 0x80), and holds the block until the permutation stage takes it.
module sha3_padding_unit #(
  parameter int R_BLOCK_SIZE = 1152
) (
  input logic                i_clk,
  input logic                i_rstN,
  input logic                i_ce,
  sha3_padding_unit_if.slave bus
);
  localparam int NW = R_BLOCK_SIZE / 64;
  localparam int NB = R_BLOCK_SIZE / 8;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [1:0] {FILL, HOLD, EXTRA} state_t;

  state_t             r_state, w_stateNext;
  logic [CW-1:0]      r_cnt, w_cntNext;
  logic [NB-1:0][7:0] r_buf, w_bufNext;
  logic               r_lastFlag, w_lastNext;
  logic               r_extraPending, w_extraNext;
  logic               w_accept, w_transfer, w_finalSlot;
  logic [3:0]         w_bytes;
  logic [0:R_BLOCK_SIZE-1] w_blockOut;

  assign w_accept    = i_ce && bus.dataValid && (r_state == FILL);
  assign w_transfer  = i_ce && bus.permReady && (r_state != FILL);
  assign w_bytes     = (bus.dataBytes > 4'd8) ? 4'd8 : bus.dataBytes;
  assign w_finalSlot = (r_cnt == CW'(NW - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_state        <= FILL;
      r_cnt          <= '0;
      r_buf          <= '0;
      r_lastFlag     <= 1'b0;
      r_extraPending <= 1'b0;
    end else if (i_ce) begin
      r_state        <= w_stateNext;
      r_cnt          <= w_cntNext;
      r_buf          <= w_bufNext;
      r_lastFlag     <= w_lastNext;
      r_extraPending <= w_extraNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_bufNext   = r_buf;
    w_lastNext  = r_lastFlag;
    w_extraNext = r_extraPending;
    case (r_state)
      FILL: begin
        if (w_accept) begin
          // Decoded per byte so the slot write needs no variable index into the buffer.
          for (int s = 0; s < NW; s++) begin
            for (int j = 0; j < 8; j++) begin
              if (s == int'(r_cnt)) begin
                if (!bus.dataLast || j < int'(w_bytes))
                  w_bufNext[s*8+j] = bus.dataIn[8*j +: 8];
                else if (j == int'(w_bytes))
                  w_bufNext[s*8+j] = 8'h06;
                else
                  w_bufNext[s*8+j] = 8'h00;
              end
              if (bus.dataLast && w_bytes == 4'd8 && !w_finalSlot &&
                  s == int'(r_cnt) + 1 && j == 0)
                w_bufNext[s*8+j] = 8'h06;
            end
          end
          if (!bus.dataLast) begin
            if (w_finalSlot) begin
              w_stateNext = HOLD;
              w_lastNext  = 1'b0;
            end else begin
              w_cntNext = r_cnt + CW'(1);
            end
          end else if (w_bytes != 4'd8 || !w_finalSlot) begin
            // OR rather than overwrite so a 0x06 already in the last byte becomes 0x86.
            w_bufNext[NB-1] = w_bufNext[NB-1] | 8'h80;
            w_stateNext     = HOLD;
            w_lastNext      = 1'b1;
          end else begin
            w_stateNext = HOLD;
            w_lastNext  = 1'b0;
            w_extraNext = 1'b1;
          end
        end
      end
      HOLD: begin
        if (w_transfer) begin
          w_bufNext = '0;
          w_cntNext = '0;
          if (r_extraPending) begin
            w_bufNext[0]    = 8'h06;
            w_bufNext[NB-1] = 8'h80;
            w_stateNext     = EXTRA;
            w_lastNext      = 1'b1;
          end else begin
            w_stateNext = FILL;
            w_lastNext  = 1'b0;
          end
        end
      end
      EXTRA: begin
        if (w_transfer) begin
          w_bufNext   = '0;
          w_cntNext   = '0;
          w_stateNext = FILL;
          w_lastNext  = 1'b0;
          w_extraNext = 1'b0;
        end
      end
      default: w_stateNext = FILL;
    endcase
  end

  always_comb begin
    w_blockOut = '0;
    for (int b = 0; b < NB; b++)
      w_blockOut[8*b +: 8] = r_buf[b];
  end

  assign bus.blockOut   = w_blockOut;
  assign bus.blockValid = (r_state != FILL);
  assign bus.blockLast  = r_lastFlag;
  assign bus.dataReady  = (r_state == FILL);
endmodule
